// File: rtl/piano_pkg.sv
// Shared piano definitions: PS/2 prefix bytes, note index width and the
// scan-code parser state type.
package piano_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int NOTE_W = 5;
  localparam logic [NOTE_W-1:0] NOTE_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BRK
  } ps2_state_e;

endpackage

// File: rtl/ps2_note_lut.sv
// Combinational PS/2 scan code to note index map; 0 means the key is not part
// of the keyboard and is ignored by every consumer.
module ps2_note_lut
  import piano_pkg::*;
(
  input  logic [7:0]        code,
  output logic [NOTE_W-1:0] note
);

  always_comb begin
    case (code)
      8'h58:   note = 5'd1;
      8'h1C:   note = 5'd2;
      8'h1B:   note = 5'd3;
      8'h23:   note = 5'd4;
      8'h2B:   note = 5'd5;
      8'h34:   note = 5'd6;
      8'h33:   note = 5'd7;
      8'h3B:   note = 5'd8;
      8'h42:   note = 5'd9;
      8'h4B:   note = 5'd10;
      8'h4C:   note = 5'd11;
      8'h52:   note = 5'd12;
      8'h5A:   note = 5'd13;
      8'h6B:   note = 5'd14;
      8'h12:   note = 5'd15;
      8'h1A:   note = 5'd16;
      8'h22:   note = 5'd17;
      8'h21:   note = 5'd18;
      8'h2A:   note = 5'd19;
      8'h32:   note = 5'd20;
      8'h31:   note = 5'd21;
      default: note = NOTE_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_voice_scheduler.sv
// Turns PS/2 scan-code bytes into key events and assigns held keys to
// tone-generator voices, stealing the oldest voice when all are busy.
module ps2_voice_scheduler
  import piano_pkg::*;
#(
  parameter int NVOICE = 4,
  parameter int AGE_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     code_valid,
  input  logic [7:0]               code,
  input  logic                     panic,
  output logic [NOTE_W*NVOICE-1:0] voice_note,
  output logic [NVOICE-1:0]        voice_on,
  output logic                     steal,
  output logic                     key_evt
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_ONE = 1;

  ps2_state_e        state_q, state_d;
  logic [NOTE_W-1:0] note_q [NVOICE];
  logic [NOTE_W-1:0] note_d [NVOICE];
  logic [AGE_W-1:0]  age_q  [NVOICE];
  logic [AGE_W-1:0]  age_d  [NVOICE];
  logic [NVOICE-1:0] on_q, on_d;
  logic              steal_q, steal_d;
  logic              key_evt_q, key_evt_d;

  logic [NOTE_W-1:0] lut_note;
  logic              is_press, is_release;
  logic              hit, free;
  int                hit_idx, free_idx, old_idx, sel_idx;
  logic [AGE_W-1:0]  best_age;

  ps2_note_lut u_lut (
    .code (code),
    .note (lut_note)
  );

  // Voice lookup: held-note match, lowest free slot, and oldest slot (ties to lowest index).
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 0;
    free     = 1'b0;
    free_idx = 0;
    old_idx  = 0;
    best_age = '0;
    for (int i = 0; i < NVOICE; i++) begin
      if (on_q[i] && note_q[i] == lut_note) begin
        hit     = 1'b1;
        hit_idx = i;
      end
      if (!on_q[i] && !free) begin
        free     = 1'b1;
        free_idx = i;
      end
      if (i == 0 || age_q[i] > best_age) begin
        best_age = age_q[i];
        old_idx  = i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    age_d      = age_q;
    on_d       = on_q;
    steal_d    = 1'b0;
    key_evt_d  = 1'b0;
    sel_idx    = free ? free_idx : old_idx;
    is_press   = code_valid && state_q == IDLE && code != SC_BREAK &&
                 code != SC_EXT && lut_note != NOTE_NONE;
    is_release = code_valid && state_q == BREAK && lut_note != NOTE_NONE;

    if (panic) begin
      state_d = IDLE;
      on_d    = '0;
      for (int i = 0; i < NVOICE; i++) begin
        note_d[i] = NOTE_NONE;
        age_d[i]  = '0;
      end
    end else begin
      if (code_valid) begin
        case (state_q)
          IDLE:    state_d = (code == SC_BREAK) ? BREAK : (code == SC_EXT) ? EXT : IDLE;
          BREAK:   state_d = IDLE;
          EXT:     state_d = (code == SC_BREAK) ? EXT_BRK : IDLE;
          default: state_d = IDLE;
        endcase
      end

      // A press of an already-held note is typematic repeat and changes nothing.
      if (is_press && !hit) begin
        steal_d   = !free;
        key_evt_d = 1'b1;
        for (int i = 0; i < NVOICE; i++) begin
          if (i == sel_idx) begin
            note_d[i] = lut_note;
            on_d[i]   = 1'b1;
            age_d[i]  = '0;
          end else if (on_q[i] && age_q[i] != AGE_MAX) begin
            age_d[i] = age_q[i] + AGE_ONE;
          end
        end
      end else if (is_release && hit) begin
        key_evt_d = 1'b1;
        for (int i = 0; i < NVOICE; i++) begin
          if (i == hit_idx) begin
            note_d[i] = NOTE_NONE;
            on_d[i]   = 1'b0;
            age_d[i]  = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      note_q    <= '{default: '0};
      age_q     <= '{default: '0};
      on_q      <= '0;
      steal_q   <= 1'b0;
      key_evt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      age_q     <= age_d;
      on_q      <= on_d;
      steal_q   <= steal_d;
      key_evt_q <= key_evt_d;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int i = 0; i < NVOICE; i++) begin
      voice_note[NOTE_W*i +: NOTE_W] = note_q[i];
    end
  end

  assign voice_on = on_q;
  assign steal    = steal_q;
  assign key_evt  = key_evt_q;

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Self-checking bench for ps2_voice_scheduler: directed scenarios followed by
// random byte streams, all compared against a behavioural keyboard model.
module tb_ps2_voice_scheduler;

  localparam int NV      = 4;
  localparam int AGE_SAT = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            code_valid;
  logic [7:0]      code;
  logic            panic;
  logic [5*NV-1:0] voice_note;
  logic [NV-1:0]   voice_on;
  logic            steal;
  logic            key_evt;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: what each voice holds, its age, and pending prefixes.
  int mNote [NV];
  int mAge  [NV];
  bit mOn   [NV];
  bit gotBreak, gotExt;
  bit expSteal, expKey;

  logic [7:0] scTable [21] = '{8'h58, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
                               8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h5A, 8'h6B,
                               8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31};

  ps2_voice_scheduler #(.NVOICE(NV), .AGE_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .panic      (panic),
    .voice_note (voice_note),
    .voice_on   (voice_on),
    .steal      (steal),
    .key_evt    (key_evt)
  );

  always #5 clk = ~clk;

  function automatic int mapCode(input logic [7:0] b);
    for (int k = 0; k < 21; k++) begin
      if (scTable[k] == b) return k + 1;
    end
    return 0;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NV; i++) begin
      mNote[i] = 0;
      mAge[i]  = 0;
      mOn[i]   = 1'b0;
    end
    gotBreak = 1'b0;
    gotExt   = 1'b0;
  endtask

  task automatic modelPress(input int n);
    int chosen;
    if (n == 0) return;
    for (int i = 0; i < NV; i++) begin
      if (mOn[i] && mNote[i] == n) return;
    end
    chosen = -1;
    for (int i = NV - 1; i >= 0; i--) begin
      if (!mOn[i]) chosen = i;
    end
    if (chosen < 0) begin
      chosen = 0;
      for (int i = 1; i < NV; i++) begin
        if (mAge[i] > mAge[chosen]) chosen = i;
      end
      expSteal = 1'b1;
    end
    for (int i = 0; i < NV; i++) begin
      if (i != chosen && mOn[i]) mAge[i] = (mAge[i] < AGE_SAT) ? mAge[i] + 1 : AGE_SAT;
    end
    mNote[chosen] = n;
    mOn[chosen]   = 1'b1;
    mAge[chosen]  = 0;
    expKey = 1'b1;
  endtask

  task automatic modelRelease(input int n);
    if (n == 0) return;
    for (int i = 0; i < NV; i++) begin
      if (mOn[i] && mNote[i] == n) begin
        mNote[i] = 0;
        mOn[i]   = 1'b0;
        mAge[i]  = 0;
        expKey   = 1'b1;
      end
    end
  endtask

  task automatic modelStep(input bit v, input logic [7:0] b, input bit p);
    expSteal = 1'b0;
    expKey   = 1'b0;
    if (p) begin
      modelClear();
    end else if (v) begin
      if (!gotExt && !gotBreak) begin
        if (b == 8'hF0)      gotBreak = 1'b1;
        else if (b == 8'hE0) gotExt = 1'b1;
        else                 modelPress(mapCode(b));
      end else if (!gotExt) begin
        modelRelease(mapCode(b));
        gotBreak = 1'b0;
      end else if (!gotBreak) begin
        if (b == 8'hF0) gotBreak = 1'b1;
        else            gotExt = 1'b0;
      end else begin
        gotExt   = 1'b0;
        gotBreak = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] b, input bit p);
    @(negedge clk);
    code_valid = v;
    code       = b;
    panic      = p;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    panic      = 1'b0;
    modelStep(v, b, p);
  endtask

  task automatic checkOutput(input string tag);
    logic [5*NV-1:0] expNote;
    logic [NV-1:0]   expOn;
    for (int i = 0; i < NV; i++) begin
      expNote[5*i +: 5] = 5'(mNote[i]);
      expOn[i]          = mOn[i];
    end
    testCount++;
    assert (voice_note === expNote) else begin
      failCount++;
      $error("[TB] FAIL %s voice_note: got %h expected %h", tag, voice_note, expNote);
    end
    testCount++;
    assert (voice_on === expOn) else begin
      failCount++;
      $error("[TB] FAIL %s voice_on: got %b expected %b", tag, voice_on, expOn);
    end
    testCount++;
    assert (steal === expSteal) else begin
      failCount++;
      $error("[TB] FAIL %s steal: got %b expected %b", tag, steal, expSteal);
    end
    testCount++;
    assert (key_evt === expKey) else begin
      failCount++;
      $error("[TB] FAIL %s key_evt: got %b expected %b", tag, key_evt, expKey);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    testCount++;
    assert (got === want) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input string tag);
    applyStimulus(1'b1, b, 1'b0);
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rv, rp;
    int         r;

    rst_n      = 1'b0;
    code_valid = 1'b0;
    code       = 8'h00;
    panic      = 1'b0;
    modelClear();
    expSteal = 1'b0;
    expKey   = 1'b0;
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    sendByte(8'h1C, "press_1C");
    checkValue("first_note", 32'(voice_note[4:0]), 32'd2);
    checkValue("first_key_evt", 32'(key_evt), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("idle_after_press");
    sendByte(8'hF0, "rel_prefix");
    sendByte(8'h1C, "rel_1C");
    checkValue("release_on", 32'(voice_on), 32'd0);
    sendByte(8'hF0, "rel_prefix_unmapped");
    sendByte(8'h99, "rel_unmapped");

    sendByte(8'h1C, "fill_v0");
    sendByte(8'h1B, "fill_v1");
    sendByte(8'h23, "fill_v2");
    sendByte(8'h2B, "fill_v3");
    sendByte(8'h34, "steal_v0");
    checkValue("steal_note", 32'(voice_note[4:0]), 32'd6);
    checkValue("steal_pulse", 32'(steal), 32'd1);
    sendByte(8'hF0, "stolen_rel_prefix");
    sendByte(8'h1C, "stolen_rel");

    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("panic_clear");
    for (int k = 0; k < 5; k++) sendByte(8'h1C, "typematic");

    sendByte(8'hE0, "ext_prefix");
    sendByte(8'h6B, "ext_key");
    sendByte(8'hE0, "extbrk_prefix1");
    sendByte(8'hF0, "extbrk_prefix2");
    sendByte(8'h6B, "extbrk_key");
    sendByte(8'h6B, "recovered_6B");
    checkValue("recovered_note", 32'(voice_note[9:5]), 32'd14);

    sendByte(8'h23, "pre_panic_a");
    sendByte(8'h2B, "pre_panic_b");
    applyStimulus(1'b1, 8'h31, 1'b1);
    checkOutput("panic_with_byte");
    checkValue("panic_on", 32'(voice_on), 32'd0);

    sendByte(8'hF0, "reset_mid_prefix");
    #2;
    rst_n = 1'b0;
    modelClear();
    expSteal = 1'b0;
    expKey   = 1'b0;
    #2;
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sendByte(8'h1A, "after_reset_1A");
    checkValue("after_reset_note", 32'(voice_note[4:0]), 32'd16);

    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 99));
      rv = ($urandom_range(0, 9) != 0);
      rp = ($urandom_range(0, 59) == 0);
      if (r < 18)      rb = 8'hF0;
      else if (r < 22) rb = 8'hE0;
      else if (r < 28) rb = 8'($urandom_range(0, 255));
      else             rb = scTable[$urandom_range(0, 7)];
      applyStimulus(rv, rb, rp);
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
